fifo3_read_ctrl: RTL and testbench

//   Read-side controller for the 3x32 instruction FIFO. Tracks occupancy from writer push strobes.

---
 rtl/fifo3_pkg.sv | 26 ++
 rtl/skid_reg2.sv | 77 +++++++
 rtl/fifo3_read_ctrl.sv | 155 +++++++++++++++
 tb/tb_fifo3_read_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo3_pkg.sv
// ============================================================================
//  Module      : fifo3_pkg
//  Description : Shared constants and state encoding for the 3x32
//                instruction-FIFO read controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo3_pkg;

  localparam int DEPTH = 3;   // FIFO entries
  localparam int DW    = 32;  // data width
  localparam int CNT_W = 2;   // width of count and read index

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/skid_reg2.sv
// ============================================================================
//  Module      : skid_reg2
//  Description : Two-entry holding stage (output reg + skid reg) between the
//                FIFO read data and the decode valid/ready stream. A word
//                arriving while the output reg is empty is presented straight
//                away and parked in the output reg only if decode stalls.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                flush          - drop held words and the arriving word
//                in_valid/in_data - captured FIFO word (in-flight read)
//                out_valid/out_ready/out_data - decode stream
//                held           - number of words parked (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_reg2
  import fifo3_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    held
);

  logic          o_v;
  logic          s_v;
  logic [DW-1:0] o_d;
  logic [DW-1:0] s_d;
  logic          byp;
  logic          fire;

  // The arriving word goes straight to decode when nothing older is parked.
  assign byp       = in_valid & ~o_v & ~flush;
  assign out_valid = o_v | byp;
  assign out_data  = o_v ? o_d : (byp ? in_data : '0);
  assign fire      = out_valid & out_ready;
  assign held      = {1'b0, o_v} + {1'b0, s_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      o_d <= '0;
      s_d <= '0;
    end else if (flush) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
    end else if (o_v) begin
      if (fire) begin
        // Skid word always moves up before the arriving word.
        if (s_v) begin
          o_d <= s_d;
          s_v <= in_valid;
          if (in_valid) s_d <= in_data;
        end else begin
          o_v <= in_valid;
          if (in_valid) o_d <= in_data;
        end
      end else if (in_valid) begin
        // Parent's credit check guarantees the skid slot is free here.
        s_v <= 1'b1;
        s_d <= in_data;
      end
    end else if (in_valid && !out_ready) begin
      o_v <= 1'b1;
      o_d <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo3_read_ctrl.sv
// ============================================================================
//  Module      : fifo3_read_ctrl
//  Description : Read-side controller for the 3x32 instruction FIFO. Tracks
//                occupancy from writer pushes, issues read/increment/clear
//                strobes, absorbs the FIFO's 1-cycle read latency and feeds
//                decode on a valid/ready stream. Handles redirect flush.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                wr_inc          - writer pushed a word this cycle
//                flush           - discard queued and in-flight words
//                fifo_data       - FIFO DataOut (valid cycle after fifo_rden)
//                fifo_rden/fifo_rd_inc/fifo_rd_clr/fifo_wr_clr - FIFO strobes
//                out_valid/out_ready/out_data - decode stream
//                count, full, overflow - occupancy status
//                pop_cnt, starve_cnt   - statistics (QREAD_STATS_EN only)
//  Config      : define QREAD_STATS_EN to add the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo3_read_ctrl
  import fifo3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_inc,
  input  logic             flush,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_rden,
  output logic             fifo_rd_inc,
  output logic             fifo_rd_clr,
  output logic             fifo_wr_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
`ifdef QREAD_STATS_EN
  ,
  output logic [15:0]      pop_cnt,
  output logic [15:0]      starve_cnt
`endif
);

  state_t           state;
  logic [CNT_W-1:0] rd_idx;
  logic             inflight;
  logic [1:0]       held;
  logic             wr_eff;
  logic             fire;
  logic [2:0]       busy;
  logic             issue;
  logic             ovf_set;
  logic [CNT_W-1:0] cnt_nx;

  assign full   = (count == CNT_FULL);
  assign wr_eff = wr_inc & ~flush & (state != S_FLUSH);
  assign fire   = out_valid & out_ready;

  // Holding-stage slots already spoken for: parked words, the word on
  // fifo_data, and the read strobe currently out. A word leaving this cycle
  // frees its slot, which keeps a full word per cycle flowing.
  assign busy  = {1'b0, held} + {2'b00, inflight} + {2'b00, fifo_rden}
               - {2'b00, fire};

  // A push this cycle can be read straight away, so it counts as available.
  assign issue = ((count != '0) | wr_eff) & ~flush & (state != S_FLUSH)
               & (busy < 3'd2);

  assign ovf_set = wr_eff & full & ~issue;

  always_comb begin
    cnt_nx = count;
    if (wr_eff && !issue) begin
      cnt_nx = full ? count : count + 2'd1;
    end else if (!wr_eff && issue) begin
      cnt_nx = count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      rd_idx      <= '0;
      inflight    <= 1'b0;
      overflow    <= 1'b0;
      fifo_rden   <= 1'b0;
      fifo_rd_inc <= 1'b0;
      fifo_rd_clr <= 1'b0;
      fifo_wr_clr <= 1'b0;
    end else if (flush) begin
      // The read strobe out this cycle still reaches the FIFO; clearing
      // inflight drops the word it returns.
      state       <= S_FLUSH;
      count       <= '0;
      rd_idx      <= '0;
      inflight    <= 1'b0;
      fifo_rden   <= 1'b0;
      fifo_rd_inc <= 1'b0;
      fifo_rd_clr <= 1'b1;
      fifo_wr_clr <= 1'b1;
    end else begin
      inflight    <= fifo_rden;
      fifo_rden   <= issue;
      fifo_rd_inc <= issue & (rd_idx != IDX_LAST);
      fifo_rd_clr <= issue & (rd_idx == IDX_LAST);
      fifo_wr_clr <= 1'b0;
      if (issue) begin
        rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + 2'd1;
      end
      count <= cnt_nx;
      if (ovf_set) overflow <= 1'b1;

      case (state)
        S_IDLE:  if (wr_eff) state <= S_RUN;
        // Also wait for a pending strobe or push so a word is never left
        // travelling while the controller reports idle.
        S_RUN:   if (count == '0 && held == 2'd0 && !inflight &&
                     !fifo_rden && !wr_eff) state <= S_IDLE;
        S_FLUSH: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  skid_reg2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inflight),
    .in_data   (fifo_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .held      (held)
  );

`ifdef QREAD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (fire) pop_cnt <= pop_cnt + 16'd1;
      if (out_ready && !out_valid && state == S_RUN) begin
        starve_cnt <= starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo3_read_ctrl.sv
// ============================================================================
//  Module      : tb_fifo3_read_ctrl
//  Description : Self-checking bench for fifo3_read_ctrl. A queue-based FIFO
//                model answers the read strobes; pushed words go into an
//                expected-word queue that is popped when decode accepts one.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo3_read_ctrl;
  import fifo3_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_inc = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   fifo_data;
  logic          fifo_rden, fifo_rd_inc, fifo_rd_clr, fifo_wr_clr;
  logic          out_valid, full, overflow;
  logic [31:0]   out_data;
  logic [1:0]    count;
  logic          model_drop = 1'b0;
`ifdef QREAD_STATS_EN
  logic [15:0]   pop_cnt, starve_cnt;
`endif

  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   fq[$];

  always #5 clk = ~clk;

  fifo3_read_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_inc      (wr_inc),
    .flush       (flush),
    .fifo_data   (fifo_data),
    .fifo_rden   (fifo_rden),
    .fifo_rd_inc (fifo_rd_inc),
    .fifo_rd_clr (fifo_rd_clr),
    .fifo_wr_clr (fifo_wr_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .overflow    (overflow)
`ifdef QREAD_STATS_EN
    ,
    .pop_cnt     (pop_cnt),
    .starve_cnt  (starve_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: one-cycle read latency, cleared by wr_clr.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_data <= '0;
    end else begin
      if (fifo_rden) begin
        if (fq.size() != 0) fifo_data <= fq.pop_front();
        else                fifo_data <= 32'hBAD0_BAD0;
      end
      if (fifo_wr_clr)                  fq.delete();
      else if (wr_inc && !model_drop)   fq.push_back(wr_data);
    end
  end

  // Scoreboard: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underrun", 32'(exp_q.size()), 32'd1);
      else                   chk("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_inc  = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_inc  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; wr_inc = 1'b0; out_ready = 1'b0; model_drop = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] inc_pat;
  logic [4:0] clr_pat;

  initial begin
    inc_pat = 5'b11011;
    clr_pat = 5'b00100;

    // Reset state
    repeat (2) tick();
    chk("rst_rden", 32'(fifo_rden), 32'd0);
    chk("rst_rdinc", 32'(fifo_rd_inc), 32'd0);
    chk("rst_rdclr", 32'(fifo_rd_clr), 32'd0);
    chk("rst_wrclr", 32'(fifo_wr_clr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single word latency
    out_ready = 1'b1;
    push(32'hA5A5_0001);
    chk("t1_rden", 32'(fifo_rden), 32'd1);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'hA5A5_0001);
    tick();
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_idle", 32'(out_valid), 32'd0);
    drain("t1_drain");

    // 2: wrap of the read index at full throughput
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h2000_0000 + 32'(i));
      chk("t2_rden", 32'(fifo_rden), 32'd1);
      chk("t2_inc", 32'(fifo_rd_inc), 32'(inc_pat[i]));
      chk("t2_clr", 32'(fifo_rd_clr), 32'(clr_pat[i]));
      if (i >= 1) chk("t2_tput", 32'(out_valid), 32'd1);
    end
    drain("t2_drain");

    // 3: stall holds two words, release drains in order
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h3000_0000 + 32'(i));
    repeat (3) tick();
    chk("t3_count", 32'(count), 32'd1);
    chk("t3_full", 32'(full), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data", out_data, 32'h3000_0000);
    repeat (2) tick();
    chk("t3_stable", out_data, 32'h3000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_rel", 32'(out_valid), 32'd1);
      tick();
    end
    drain("t3_drain");

    // 4: full, overflow, push with same-cycle pop
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h4000_0000 + 32'(i));
    repeat (2) tick();
    chk("t4_count", 32'(count), 32'd3);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_noovf", 32'(overflow), 32'd0);
    model_drop = 1'b1; wr_inc = 1'b1; wr_data = 32'hDEAD_0005;
    tick();
    model_drop = 1'b0; wr_inc = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_sat", 32'(count), 32'd3);
    out_ready = 1'b1;
    push(32'h4000_0006);
    chk("t4_pp_count", 32'(count), 32'd3);
    chk("t4_pp_ovf", 32'(overflow), 32'd1);
    drain("t4_drain");

    // 5: flush with a read in flight and a same-cycle push
    do_reset();
    push(32'h5000_0000);
    push(32'h5000_0001);
    flush = 1'b1; wr_inc = 1'b1; wr_data = 32'h5000_0002;
    exp_q.delete();
    tick();
    flush = 1'b0; wr_inc = 1'b0;
    chk("t5_rdclr", 32'(fifo_rd_clr), 32'd1);
    chk("t5_wrclr", 32'(fifo_wr_clr), 32'd1);
    chk("t5_rden", 32'(fifo_rden), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    tick();
    chk("t5_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push(32'h5000_0010);
    push(32'h5000_0011);
    drain("t5_drain");

    // 6: rst together with flush mid-stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h6000_0000 + 32'(i));
    drain("t6_drain");
`ifdef QREAD_STATS_EN
    chk("t6_popcnt", 32'(pop_cnt), 32'd3);
`endif
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h6100_0000 + 32'(i));
    model_drop = 1'b1; wr_inc = 1'b1; wr_data = 32'hDEAD_0006;
    tick();
    model_drop = 1'b0; wr_inc = 1'b0;
    chk("t6_ovf_pre", 32'(overflow), 32'd1);
    rst = 1'b1; flush = 1'b1;
    exp_q.delete();
    tick();
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_rdclr", 32'(fifo_rd_clr), 32'd0);
    chk("t6_wrclr", 32'(fifo_wr_clr), 32'd0);
    chk("t6_rden", 32'(fifo_rden), 32'd0);
`ifdef QREAD_STATS_EN
    chk("t6_popcnt_rst", 32'(pop_cnt), 32'd0);
`endif
    rst = 1'b0; flush = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
